// File: rtl/cache_types_pkg.sv
// Shared types for the L2-to-burst-memory cache line adaptor: FSM states,
// beat count and line/beat widths.
package cache_types;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    // Byte-offset bits dropped from the line address on the burst side.
    localparam int OFFSET_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts whole-line L2 read/write requests into BEATS-beat bursts on the
// memory side, assembling read beats into a line and splitting write lines.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int BEATS = cache_types::BEATS
) (
    input  logic                       clk,
    input  logic                       rst,

    // L2 side: request held until resp_o; resp_o pulses one cycle per line.
    input  logic [LINE_W-1:0]          line_i,
    output logic [LINE_W-1:0]          line_o,
    input  logic [31:0]                address_i,
    input  logic                       read_i,
    input  logic                       write_i,
    output logic                       resp_o,

    // Memory side: read_o/write_o held for the whole burst; each resp_i
    // cycle transfers exactly one beat (burst_i captured / burst_o consumed).
    input  logic [BEAT_W-1:0]          burst_i,
    output logic [BEAT_W-1:0]          burst_o,
    output logic [31:0]                address_o,
    output logic                       read_o,
    output logic                       write_o,
    input  logic                       resp_i,

    output state_t                     dbg_state,
    output logic [$clog2(BEATS)-1:0]   dbg_cnt
);

    localparam int CW = $clog2(BEATS);

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [BEATS-1:0][BEAT_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]              line_q, line_d;
    logic [31:0]                    addr_q, addr_d;
    logic                           last_beat;

    assign last_beat = (cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_d  = line_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                // Read has priority when both requests arrive together.
                if (read_i) begin
                    addr_d  = address_i;
                    state_d = READ;
                end else if (write_i) begin
                    addr_d  = address_i;
                    buf_d   = line_i;
                    state_d = WRITE;
                end
            end

            READ: begin
                if (resp_i) begin
                    buf_d[cnt_q] = burst_i;
                    if (last_beat) begin
                        // line_o only ever changes to a fully assembled line.
                        line_d  = buf_d;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            WRITE: begin
                if (resp_i) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are decoded straight from the state register, so they are glitch-free
    // and fall in the cycle after the final beat.
    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign burst_o   = write_o ? buf_q[cnt_q] : '0;
    assign address_o = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign line_o    = line_q;

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    a_rw_exclusive : assert property (@(posedge clk) disable iff (rst) !(read_o && write_o));
    a_resp_single  : assert property (@(posedge clk) disable iff (rst) resp_o |=> !resp_o);

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: per-cycle vector table plus
// hand sequences for reset mid-burst, idle spurious acks and latency.
module tb_cacheline_adaptor;
    import cache_types::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [255:0]       line_i;
    logic [255:0]       line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [63:0]        burst_i;
    logic [63:0]        burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;
    state_t             dbg_state;
    logic [1:0]         dbg_cnt;

    int errors = 0;
    int checks = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic         rsp;
        logic [63:0]  burst;
        logic [31:0]  addr;
        logic [255:0] li;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [63:0]  e_burst;
        logic [31:0]  e_addr;
        logic [255:0] e_line;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic rsp, input logic [63:0] burst,
                       input logic [31:0] addr, input logic [255:0] li,
                       input logic e_rd, input logic e_wr, input logic e_resp,
                       input logic [63:0] e_burst, input logic [31:0] e_addr,
                       input logic [255:0] e_line);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp; v.burst = burst; v.addr = addr; v.li = li;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
        v.e_burst = e_burst; v.e_addr = e_addr; v.e_line = e_line;
        tbl.push_back(v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " read_o"},    256'(read_o),    256'(0));
        chk({tag, " write_o"},   256'(write_o),   256'(0));
        chk({tag, " resp_o"},    256'(resp_o),    256'(0));
        chk({tag, " burst_o"},   256'(burst_o),   256'(0));
        chk({tag, " address_o"}, 256'(address_o), 256'(0));
        chk({tag, " line_o"},    line_o,          256'(0));
        chk({tag, " state"},     256'(dbg_state), 256'(IDLE));
        chk({tag, " cnt"},       256'(dbg_cnt),   256'(0));
    endtask

    // Memory model with one cycle of latency before the first beat, then
    // back-to-back acks; resp_o is expected in cycle T+6 after acceptance.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [255:0] line, input logic [31:0] exp_addr);
        int bi;
        int seen;
        bi = 0;
        seen = 0;
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0; burst_i = '0;
        step();
        chk({tag, " address_o"}, 256'(address_o), 256'(exp_addr));
        for (int cyc = 1; cyc <= 30; cyc++) begin
            chk({tag, " rw_exclusive"}, 256'(read_o && write_o), 256'(0));
            if (resp_o) begin
                seen = cyc;
                break;
            end
            if (cyc >= 2 && bi < 4 && read_o) begin
                resp_i = 1'b1;
                burst_i = line[64*bi +: 64];
                bi++;
            end else begin
                resp_i = 1'b0;
                burst_i = '0;
            end
            step();
        end
        if (seen == 0) begin
            chk({tag, " timeout waiting resp_o"}, 256'(0), 256'(1));
        end else begin
            chk({tag, " latency"}, 256'(seen), 256'(6));
        end
        chk({tag, " line_o"}, line_o, line);
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        step();
        chk({tag, " resp_o single pulse"}, 256'(resp_o), 256'(0));
        chk({tag, " state idle"},          256'(dbg_state), 256'(IDLE));
    endtask

    initial begin
        logic [63:0]  z64;
        logic [255:0] z256;
        logic [255:0] l1, lw, l3, l4, l5;
        logic [63:0]  a, b, c, d, bad;

        z64  = '0;
        z256 = '0;
        a = rep(8'hAA); b = rep(8'hBB); c = rep(8'hCC); d = rep(8'hDD); bad = rep(8'hEE);
        l1 = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
        lw = {d, c, b, a};
        l3 = {rep(8'h88), rep(8'h77), rep(8'h66), rep(8'h55)};
        l4 = {rep(8'h04), rep(8'h03), rep(8'h02), rep(8'h01)};
        l5 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5A5A_A5A5_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};

        // Basic read; the row after the last beat sends a stray ack in DONE.
        add(1,0,0, z64,        32'h0000_1234, z256, 1,0,0, z64, 32'h0000_1220, z256);
        add(1,0,1, rep(8'h11), 32'h0000_1234, z256, 1,0,0, z64, 32'h0000_1220, z256);
        add(1,0,1, rep(8'h22), 32'h0000_1234, z256, 1,0,0, z64, 32'h0000_1220, z256);
        add(1,0,1, rep(8'h33), 32'h0000_1234, z256, 1,0,0, z64, 32'h0000_1220, z256);
        add(1,0,1, rep(8'h44), 32'h0000_1234, z256, 0,0,1, z64, 32'h0000_1220, l1);
        add(0,0,1, bad,        32'h0000_0000, z256, 0,0,0, z64, 32'h0000_1220, l1);
        // Write; requester drops write_i after the first beat.
        add(0,1,0, z64, 32'h8000_0040, lw,   0,1,0, a,   32'h8000_0040, l1);
        add(0,1,1, z64, 32'h8000_0040, lw,   0,1,0, b,   32'h8000_0040, l1);
        add(0,0,1, z64, 32'h0000_0000, z256, 0,1,0, c,   32'h8000_0040, l1);
        add(0,0,1, z64, 32'h0000_0000, z256, 0,1,0, d,   32'h8000_0040, l1);
        add(0,0,1, z64, 32'h0000_0000, z256, 0,0,1, z64, 32'h8000_0040, l1);
        add(0,0,0, z64, 32'h0000_0000, z256, 0,0,0, z64, 32'h8000_0040, l1);
        // Simultaneous read and write: read wins.
        add(1,1,0, z64,        32'h0000_0100, lw, 1,0,0, z64, 32'h0000_0100, l1);
        add(1,1,1, rep(8'h55), 32'h0000_0100, lw, 1,0,0, z64, 32'h0000_0100, l1);
        add(1,1,1, rep(8'h66), 32'h0000_0100, lw, 1,0,0, z64, 32'h0000_0100, l1);
        add(1,1,1, rep(8'h77), 32'h0000_0100, lw, 1,0,0, z64, 32'h0000_0100, l1);
        add(1,1,1, rep(8'h88), 32'h0000_0100, lw, 0,0,1, z64, 32'h0000_0100, l3);
        add(0,0,0, z64,        32'h0000_0000, z256, 0,0,0, z64, 32'h0000_0100, l3);
        // Stalled read, ack pattern 1,0,0,1,1,0,1 with garbage on idle beats.
        add(1,0,0, z64,        32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,1, rep(8'h01), 32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,0, bad,        32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,0, bad,        32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,1, rep(8'h02), 32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,1, rep(8'h03), 32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,0, bad,        32'h0000_2010, z256, 1,0,0, z64, 32'h0000_2000, l3);
        add(1,0,1, rep(8'h04), 32'h0000_2010, z256, 0,0,1, z64, 32'h0000_2000, l4);
        add(0,0,0, z64,        32'h0000_0000, z256, 0,0,0, z64, 32'h0000_2000, l4);

        // Clock/reset block.
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
        step();
        step();
        chk_all_zero("reset");

        // First row is accepted on the first edge after rst drops.
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            read_i = tbl[i].rd; write_i = tbl[i].wr; resp_i = tbl[i].rsp;
            burst_i = tbl[i].burst; address_i = tbl[i].addr; line_i = tbl[i].li;
            step();
            chk($sformatf("row%0d read_o", i),    256'(read_o),    256'(tbl[i].e_rd));
            chk($sformatf("row%0d write_o", i),   256'(write_o),   256'(tbl[i].e_wr));
            chk($sformatf("row%0d resp_o", i),    256'(resp_o),    256'(tbl[i].e_resp));
            chk($sformatf("row%0d burst_o", i),   256'(burst_o),   256'(tbl[i].e_burst));
            chk($sformatf("row%0d address_o", i), 256'(address_o), 256'(tbl[i].e_addr));
            chk($sformatf("row%0d line_o", i),    line_o,          tbl[i].e_line);
        end

        // Spurious acks while idle must not move anything.
        read_i = 1'b0; write_i = 1'b0; line_i = '0; address_i = '0;
        for (int k = 0; k < 3; k++) begin
            resp_i = 1'b1; burst_i = bad;
            step();
            chk($sformatf("idle_ack%0d resp_o", k), 256'(resp_o),    256'(0));
            chk($sformatf("idle_ack%0d line_o", k), line_o,          l4);
            chk($sformatf("idle_ack%0d cnt", k),    256'(dbg_cnt),   256'(0));
            chk($sformatf("idle_ack%0d state", k),  256'(dbg_state), 256'(IDLE));
        end
        resp_i = 1'b0; burst_i = '0;

        // Reset after the second read beat.
        read_i = 1'b1; address_i = 32'h0000_0040;
        step();
        resp_i = 1'b1; burst_i = rep(8'h91);
        step();
        burst_i = rep(8'h92);
        step();
        chk("midburst cnt before reset", 256'(dbg_cnt), 256'(2));
        rst = 1'b1; burst_i = rep(8'h93);
        step();
        chk_all_zero("midburst_reset");
        rst = 1'b0; read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        step();
        chk("post_reset resp_o", 256'(resp_o), 256'(0));
        chk("post_reset read_o", 256'(read_o), 256'(0));

        do_read("read_after_reset", 32'h0000_0040, l5, 32'h0000_0040);
        do_read("read_high_addr",   32'hFFFF_FFFF, l1, 32'hFFFF_FFE0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
